gate_tt_checker: RTL and testbench

- Synthesizable truth-table sequencer and response checker for small combinational gates (nor_gate and its siblings).
- Drives every input vector of the gate under test in turn and samples the gate output after a settle interval.
- Compares each sample against a parameterised expected truth table, then reports pass/fail, mismatch count and the first failing vector.
- Sits opposite the gate's input side: this block generates stimulus and receives/judges the gate response, so gate checks can run on-chip or in a bench.

---
 rtl/gate_tt_checker.sv | 156 +++++++++++++++
 tb/tb_gate_tt_checker.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/gate_tt_checker.sv
// gate_tt_checker
// Truth-table sequencer and response checker for a small combinational gate.
// A scan drives every input vector of the gate under test in ascending order,
// holds each one for SETTLE cycles, then samples the gate output on the
// following edge. Each sample is compared against the expected truth table
// EXPECT, and the block reports pass/fail, the mismatch count and the first
// failing vector.
//
// Parameters:
//   N_IN    number of gate inputs (1..4)
//   EXPECT  expected output per vector; bit i is the expected gate output
//           when in_vec == i (default is a 2-input NOR)
//   SETTLE  cycles each vector is held before it is sampled (1..15)
//
// Ports:
//   clk               rising-edge clock
//   rst               asynchronous active-high reset
//   start             one-cycle scan request, only looked at in IDLE
//   dut_out           output of the gate under test
//   in_vec            vector driven to the gate (bit 0 -> in1, bit 1 -> in2)
//   busy              high from the cycle after an accepted start until DONE exits
//   done              one-cycle pulse when the scan is complete
//   pass              1 when no vector mismatched; held until the next start
//   err_count         number of mismatching vectors
//   first_fail_vec    first vector that mismatched
//   first_fail_valid  set at the first mismatch of a scan
module gate_tt_checker #(
  parameter int                  N_IN   = 2,
  parameter logic [2**N_IN-1:0]  EXPECT = 4'b0001,
  parameter int                  SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] in_vec,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  localparam logic [N_IN-1:0] LAST_VEC    = N_IN'(2**N_IN - 1);
  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t          state, state_d;
  logic [3:0]      cnt, cnt_d;
  logic [N_IN-1:0] in_vec_d;
  logic            busy_d, done_d, pass_d;
  logic [N_IN:0]   err_count_d;
  logic [N_IN-1:0] first_fail_vec_d;
  logic            first_fail_valid_d;
  logic            mismatch;

  assign mismatch = (dut_out != EXPECT[in_vec]);

  // Next-state and next-output logic. Every output is registered, so busy
  // and done are derived from the state being entered rather than the
  // current one. pass is computed on the way into DONE so that it already
  // includes the result of the final vector.
  always_comb begin
    state_d            = state;
    cnt_d              = cnt;
    in_vec_d           = in_vec;
    pass_d             = pass;
    err_count_d        = err_count;
    first_fail_vec_d   = first_fail_vec;
    first_fail_valid_d = first_fail_valid;

    case (state)
      S_IDLE: begin
        if (start) begin
          in_vec_d           = '0;
          err_count_d        = '0;
          first_fail_valid_d = 1'b0;
          first_fail_vec_d   = '0;
          pass_d             = 1'b0;
          cnt_d              = '0;
          state_d            = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end

      S_SAMPLE: begin
        if (mismatch) begin
          err_count_d = err_count + 1'b1;
          if (!first_fail_valid) begin
            first_fail_vec_d   = in_vec;
            first_fail_valid_d = 1'b1;
          end
        end
        if (in_vec == LAST_VEC) begin
          state_d = S_DONE;
          pass_d  = (err_count_d == '0);
        end else begin
          in_vec_d = in_vec + 1'b1;
          cnt_d    = '0;
          state_d  = S_SETTLE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; reset aborts any scan in progress at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      cnt              <= '0;
      in_vec           <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      state            <= state_d;
      cnt              <= cnt_d;
      in_vec           <= in_vec_d;
      busy             <= busy_d;
      done             <= done_d;
      pass             <= pass_d;
      err_count        <= err_count_d;
      first_fail_vec   <= first_fail_vec_d;
      first_fail_valid <= first_fail_valid_d;
    end
  end

endmodule

// File: tb/tb_gate_tt_checker.sv
// tb_gate_tt_checker
// Self-checking bench for gate_tt_checker. Two checkers share the clock and
// reset: one with default parameters (SETTLE=1) and one with SETTLE=3. The
// simulated gate under test is a 4-entry truth table gateTab indexed by the
// checker's in_vec. Expected timing and results come from a reference model
// that evaluates a 2-input NOR directly and counts how many table entries
// disagree with it.
module tb_gate_tt_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0;
  logic       start3 = 1'b0;
  logic [3:0] gateTab = 4'b0001;

  logic [1:0] inVec1, inVec3, ffVec1, ffVec3;
  logic [2:0] errCnt1, errCnt3;
  logic       busy1, busy3, done1, done3, pass1, pass3, ffValid1, ffValid3;
  logic       dutOut1, dutOut3;

  int checks = 0;
  int errors = 0;

  // Observation mux: sel=0 looks at the SETTLE=1 checker, sel=1 at SETTLE=3.
  logic       sel = 1'b0;
  logic [1:0] oInVec, oFfVec;
  logic [2:0] oErrCnt;
  logic       oBusy, oDone, oPass, oFfValid;

  assign dutOut1 = gateTab[inVec1];
  assign dutOut3 = gateTab[inVec3];

  always #5 clk = ~clk;

  always_comb begin
    if (sel) begin
      oInVec = inVec3; oFfVec = ffVec3; oErrCnt = errCnt3;
      oBusy = busy3; oDone = done3; oPass = pass3; oFfValid = ffValid3;
    end else begin
      oInVec = inVec1; oFfVec = ffVec1; oErrCnt = errCnt1;
      oBusy = busy1; oDone = done1; oPass = pass1; oFfValid = ffValid1;
    end
  end

  gate_tt_checker #(.N_IN(2), .EXPECT(4'b0001), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .dut_out(dutOut1),
    .in_vec(inVec1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(errCnt1), .first_fail_vec(ffVec1), .first_fail_valid(ffValid1)
  );

  gate_tt_checker #(.N_IN(2), .EXPECT(4'b0001), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .dut_out(dutOut3),
    .in_vec(inVec3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(errCnt3), .first_fail_vec(ffVec3), .first_fail_valid(ffValid3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("[TB] check %s", tag);
    end
  endtask

  // Reference model: the intended gate is a 2-input NOR; count every table
  // entry that disagrees with it and note the lowest such vector.
  task automatic refScan(input logic [3:0] tab, output int errs, output int firstVec, output int firstValid);
    errs = 0; firstVec = 0; firstValid = 0;
    for (int v = 0; v < 4; v++) begin
      int norOut;
      norOut = ((v & 3) == 0) ? 1 : 0;
      if (int'(tab[v]) != norOut) begin
        if (firstValid == 0) begin
          firstVec = v;
          firstValid = 1;
        end
        errs++;
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_in_vec"}, 32'(oInVec), 0);
    checkOutput({tag, "_busy"}, 32'(oBusy), 0);
    checkOutput({tag, "_done"}, 32'(oDone), 0);
    checkOutput({tag, "_pass"}, 32'(oPass), 0);
    checkOutput({tag, "_err_count"}, 32'(oErrCnt), 0);
    checkOutput({tag, "_ff_vec"}, 32'(oFfVec), 0);
    checkOutput({tag, "_ff_valid"}, 32'(oFfValid), 0);
  endtask

  // One full scan on the selected checker. extraStart gives an edge index
  // (counted from the accepting edge 0) at which start is pulsed again; it
  // must have no effect. A value of 0 means no extra pulse.
  task automatic applyStimulus(input logic which, input logic [3:0] tab, input int extraStart);
    int s, total, errs, firstVec, firstValid;
    sel = which;
    s = which ? 3 : 1;
    total = 4 * (s + 1);
    gateTab = tab;
    refScan(tab, errs, firstVec, firstValid);

    @(negedge clk);
    if (which) start3 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
    checkOutput("start_busy", 32'(oBusy), 1);
    checkOutput("start_in_vec", 32'(oInVec), 0);
    checkOutput("start_err_cleared", 32'(oErrCnt), 0);
    checkOutput("start_ff_cleared", 32'(oFfValid), 0);
    checkOutput("start_pass_cleared", 32'(oPass), 0);

    for (int k = 1; k <= total + 1; k++) begin
      if (k == extraStart) begin
        if (which) start3 = 1'b1; else start1 = 1'b1;
      end
      @(negedge clk);
      start1 = 1'b0; start3 = 1'b0;
      if (k <= total) begin
        checkOutput("scan_in_vec", 32'(oInVec), (k < total) ? 32'(k / (s + 1)) : 32'd3);
        checkOutput("scan_busy", 32'(oBusy), 1);
        checkOutput("scan_done", 32'(oDone), (k == total) ? 1 : 0);
      end
      if (k >= total) begin
        checkOutput("result_pass", 32'(oPass), (errs == 0) ? 1 : 0);
        checkOutput("result_err_count", 32'(oErrCnt), 32'(errs));
        checkOutput("result_ff_valid", 32'(oFfValid), 32'(firstValid));
        checkOutput("result_ff_vec", 32'(oFfVec), 32'(firstVec));
      end
      if (k == total + 1) begin
        checkOutput("exit_busy", 32'(oBusy), 0);
        checkOutput("exit_done", 32'(oDone), 0);
        checkOutput("exit_in_vec_hold", 32'(oInVec), 3);
      end
    end

    // One more idle cycle: nothing may have restarted.
    @(negedge clk);
    checkOutput("idle_busy", 32'(oBusy), 0);
    checkOutput("idle_err_hold", 32'(oErrCnt), 32'(errs));
  endtask

  initial begin
    // Reset state of both checkers.
    #2;
    sel = 1'b0; #1 checkAllZero("reset1");
    sel = 1'b1; #1 checkAllZero("reset3");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Correct NOR, defaults.
    applyStimulus(1'b0, 4'b0001, 0);
    // Stuck-at-0 output: only vector 0 mismatches.
    applyStimulus(1'b0, 4'b0000, 0);
    // OR gate instead of NOR: every vector mismatches.
    applyStimulus(1'b0, 4'b1110, 0);
    // SETTLE=3 with a correct gate and a stray start at edge 5.
    applyStimulus(1'b1, 4'b0001, 5);
    // start coinciding with the DONE cycle must be ignored.
    applyStimulus(1'b0, 4'b0001, 9);

    // Reset at edge 4 mid-scan: outputs clear at once, no done follows.
    sel = 1'b0;
    gateTab = 4'b0001;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checkAllZero("async_reset");
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checkOutput("post_reset_done", 32'(oDone), 0);
      checkOutput("post_reset_busy", 32'(oBusy), 0);
    end
    applyStimulus(1'b0, 4'b0001, 0);

    // Back-to-back: faulty gate then correct gate.
    applyStimulus(1'b0, 4'b0000, 0);
    applyStimulus(1'b0, 4'b0001, 0);

    // Randomized gate tables on both checkers.
    for (int r = 0; r < 6; r++) begin
      applyStimulus(1'(r % 2), 4'($urandom_range(0, 15)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
